// File: rtl/fb_load_ctrl_if.sv
// Memory read port and filter-buffer write port of the filter-buffer load manager.
// The master modport is the load manager; the slave modport is the memory/buffer side.
interface fb_load_ctrl_if #(
    parameter int W_ADDR    = 32,
    parameter int W_DATA    = 64,
    parameter int W_FB_ADDR = 12
);
    logic                 o_rd_req;
    logic [W_ADDR-1:0]    o_rd_addr;
    logic                 i_rd_gnt;
    logic                 i_rd_valid;
    logic [W_DATA-1:0]    i_rd_data;
    logic                 o_fb_we;
    logic [W_FB_ADDR-1:0] o_fb_addr;
    logic [W_DATA-1:0]    o_fb_wdata;

    modport master (
        output o_rd_req, o_rd_addr, o_fb_we, o_fb_addr, o_fb_wdata,
        input  i_rd_gnt, i_rd_valid, i_rd_data
    );

    modport slave (
        input  o_rd_req, o_rd_addr, o_fb_we, o_fb_addr, o_fb_wdata,
        output i_rd_gnt, i_rd_valid, i_rd_data
    );
endinterface

// File: rtl/fb_load_ctrl.sv
// Filter-buffer load manager: on a controller request, fetches one output-channel tile of
// filter words through an in-order read port and writes them into the filter buffer.
module fb_load_ctrl #(
    parameter int W_CHANNEL       = 4,
    parameter int W_ADDR          = 32,
    parameter int W_DATA          = 64,
    parameter int W_WORDS         = 12,
    parameter int W_FB_ADDR       = 12,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 q_start,
    input  logic [W_ADDR-1:0]    q_fb_base_addr,
    input  logic [W_WORDS-1:0]   q_words_per_tile,
    input  logic                 fb_load_req,
    input  logic [W_CHANNEL-1:0] i_chn_out,
    fb_load_ctrl_if.master       bus,
    output logic                 o_fb_load_done,
    output logic                 o_busy,
    output logic                 o_err
);
    localparam int BYTES = W_DATA / 8;
    localparam int W_OUT = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [2:0] {S_IDLE, S_CALC, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [W_ADDR-1:0]    cfg_base_q, cfg_base_d;
    logic [W_WORDS-1:0]   cfg_words_q, cfg_words_d;
    logic [W_CHANNEL-1:0] chn_q, chn_d;
    logic [W_ADDR-1:0]    tile_base_q, tile_base_d;
    logic [W_WORDS-1:0]   issued_q, issued_d;
    logic [W_WORDS-1:0]   received_q, received_d;
    logic [W_OUT-1:0]     outstanding_q, outstanding_d;
    logic                 err_q, err_d;
    logic                 fb_we_q, fb_we_d;
    logic [W_FB_ADDR-1:0] fb_addr_q, fb_addr_d;
    logic [W_DATA-1:0]    fb_wdata_q, fb_wdata_d;

    logic rd_req;
    logic grant;
    logic accept;
    logic last_grant;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= S_IDLE;
            cfg_base_q    <= '0;
            cfg_words_q   <= '0;
            chn_q         <= '0;
            tile_base_q   <= '0;
            issued_q      <= '0;
            received_q    <= '0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
            fb_we_q       <= 1'b0;
            fb_addr_q     <= '0;
            fb_wdata_q    <= '0;
        end else begin
            state_q       <= state_d;
            cfg_base_q    <= cfg_base_d;
            cfg_words_q   <= cfg_words_d;
            chn_q         <= chn_d;
            tile_base_q   <= tile_base_d;
            issued_q      <= issued_d;
            received_q    <= received_d;
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
            fb_we_q       <= fb_we_d;
            fb_addr_q     <= fb_addr_d;
            fb_wdata_q    <= fb_wdata_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cfg_base_d    = cfg_base_q;
        cfg_words_d   = cfg_words_q;
        chn_d         = chn_q;
        tile_base_d   = tile_base_q;
        issued_d      = issued_q;
        received_d    = received_q;
        outstanding_d = outstanding_q;
        err_d         = err_q;
        fb_we_d       = 1'b0;
        fb_addr_d     = fb_addr_q;
        fb_wdata_d    = fb_wdata_q;

        rd_req     = (state_q == S_ISSUE) && (issued_q < cfg_words_q)
                     && (outstanding_q < W_OUT'(MAX_OUTSTANDING));
        grant      = rd_req && bus.i_rd_gnt;
        last_grant = grant && (({1'b0, issued_q} + (W_WORDS+1)'(1)) == {1'b0, cfg_words_q});
        // Outstanding is only ever non-zero in ISSUE/DRAIN, so this also rejects stray data.
        accept     = bus.i_rd_valid && (outstanding_q != '0)
                     && ((state_q == S_ISSUE) || (state_q == S_DRAIN));

        if (q_start) begin
            cfg_base_d  = q_fb_base_addr;
            cfg_words_d = q_words_per_tile;
            err_d       = 1'b0;
        end
        if (fb_load_req && (state_q != S_IDLE)) err_d = 1'b1;
        if (bus.i_rd_valid && !accept)          err_d = 1'b1;

        if (grant) issued_d = issued_q + W_WORDS'(1);
        case ({grant, accept})
            2'b10:   outstanding_d = outstanding_q + W_OUT'(1);
            2'b01:   outstanding_d = outstanding_q - W_OUT'(1);
            default: outstanding_d = outstanding_q;
        endcase

        if (accept) begin
            fb_we_d    = 1'b1;
            fb_addr_d  = W_FB_ADDR'(received_q);
            fb_wdata_d = bus.i_rd_data;
            received_d = received_q + W_WORDS'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (fb_load_req) begin
                    chn_d   = i_chn_out;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                // Modular product in W_ADDR bits equals the full-width product truncated.
                tile_base_d   = cfg_base_q + W_ADDR'(chn_q) * W_ADDR'(cfg_words_q) * W_ADDR'(BYTES);
                issued_d      = '0;
                received_d    = '0;
                outstanding_d = '0;
                state_d       = (cfg_words_q == '0) ? S_DONE : S_ISSUE;
            end
            S_ISSUE: begin
                if (last_grant) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                // received reaching the count means the final write is on the bus this cycle.
                if (received_q == cfg_words_q) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.o_rd_req   = rd_req;
    assign bus.o_rd_addr  = (state_q == S_ISSUE)
                            ? tile_base_q + W_ADDR'(issued_q) * W_ADDR'(BYTES) : '0;
    assign bus.o_fb_we    = fb_we_q;
    assign bus.o_fb_addr  = fb_addr_q;
    assign bus.o_fb_wdata = fb_wdata_q;
    assign o_fb_load_done = (state_q == S_DONE);
    assign o_busy         = (state_q != S_IDLE);
    assign o_err          = err_q;
endmodule
